fst_mem_rsp: RTL and testbench

FST_MEM_RSP -- requirements
Module: fst_mem_rsp

---
 rtl/fst_mem_rsp.sv | 149 ++++++++++++++
 tb/tb_fst_mem_rsp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fst_mem_rsp.sv
// Memory response model for a walker: accepts line requests into an in-order
// FIFO, ages each entry by LAT cycles, then returns the line from a backing
// store through a valid/ready response channel.
module fst_mem_rsp #(
    parameter int unsigned MCN_W  = 58,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LAT    = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_o_valid,
    output logic                     mem_req_o_ready,
    input  logic [MCN_W-1:0]         mem_req_o_bits_mcn,
    output logic                     mem_resp_i_valid,
    input  logic                     mem_resp_i_ready,
    output logic [DATA_W-1:0]        mem_resp_i_bits_data,
    input  logic                     wr_valid_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     stall_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [3:0]  LAT_C = 4'(LAT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    // Outstanding-request FIFO: line index plus per-entry age countdown
    logic [IDX_W-1:0] fifo_idx_q [DEPTH];
    logic [3:0]       fifo_cd_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Backing store, deliberately not reset
    logic [DATA_W-1:0] mem [2**IDX_W];

    state_t            state_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  head_idx;
    logic              head_due;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_mcn_hi;

    // Upper line-number bits are dropped: the store wraps modulo 2^IDX_W
    assign req_idx       = mem_req_o_bits_mcn[IDX_W-1:0];
    assign unused_mcn_hi = ^mem_req_o_bits_mcn[MCN_W-1:IDX_W];

    assign mem_req_o_ready      = (count_q < DEPTH_C);
    assign push                 = mem_req_o_valid & mem_req_o_ready;
    assign pop                  = valid_q & mem_resp_i_ready;
    assign head_idx             = fifo_idx_q[rd_ptr_q];
    // Countdown reaching zero at this edge makes the head eligible now
    assign head_due             = (fifo_cd_q[rd_ptr_q] <= 4'd1);
    assign count_d              = count_q + CNT_W'(push) - CNT_W'(pop);
    assign count_o              = count_q;
    assign mem_resp_i_valid     = valid_q;
    assign mem_resp_i_bits_data = data_q;

    // FIFO storage, pointers, occupancy and per-entry countdown aging
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_idx_q[i] <= '0;
                fifo_cd_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wr_ptr_q == PTR_W'(i))) begin
                    fifo_idx_q[i] <= req_idx;
                    fifo_cd_q[i]  <= LAT_C;
                end else if (fifo_cd_q[i] != 4'd0) begin
                    fifo_cd_q[i] <= fifo_cd_q[i] - 4'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Backing-store write port
    always_ff @(posedge clock) begin
        if (wr_valid_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Response FSM with registered valid/data; read is write-first on index match
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (head_due && !stall_i) begin
                        state_q <= StResp;
                        valid_q <= 1'b1;
                        if (wr_valid_i && (wr_idx_i == head_idx)) begin
                            data_q <= wr_data_i;
                        end else begin
                            data_q <= mem[head_idx];
                        end
                    end
                end
                StResp: begin
                    // Held until handshake; stall and store writes cannot disturb it
                    if (mem_resp_i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= (count_d != '0) ? StWait : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fst_mem_rsp.sv
// Directed self-checking bench for fst_mem_rsp with default parameters.
module tb_fst_mem_rsp;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         mem_req_o_valid = 1'b0;
    logic         mem_req_o_ready;
    logic [57:0]  mem_req_o_bits_mcn = '0;
    logic         mem_resp_i_valid;
    logic         mem_resp_i_ready = 1'b0;
    logic [511:0] mem_resp_i_bits_data;
    logic         wr_valid_i = 1'b0;
    logic [7:0]   wr_idx_i = '0;
    logic [511:0] wr_data_i = '0;
    logic         stall_i = 1'b0;
    logic [2:0]   count_o;

    int n_checks = 0;
    int n_fail   = 0;

    fst_mem_rsp dut (
        .clock                (clock),
        .reset                (reset),
        .mem_req_o_valid      (mem_req_o_valid),
        .mem_req_o_ready      (mem_req_o_ready),
        .mem_req_o_bits_mcn   (mem_req_o_bits_mcn),
        .mem_resp_i_valid     (mem_resp_i_valid),
        .mem_resp_i_ready     (mem_resp_i_ready),
        .mem_resp_i_bits_data (mem_resp_i_bits_data),
        .wr_valid_i           (wr_valid_i),
        .wr_idx_i             (wr_idx_i),
        .wr_data_i            (wr_data_i),
        .stall_i              (stall_i),
        .count_o              (count_o)
    );

    always #5 clock = ~clock;

    localparam logic [511:0] LINE_A5  = {64{8'hA5}};
    localparam logic [511:0] LINE_NEW = {16{32'hC0DE_0007}};
    localparam logic [511:0] LINE_DEAD = {16{32'hDEAD_BEEF}};

    function automatic logic [511:0] pat(input int i);
        logic [7:0] b;
        b = 8'h10 + 8'(i);
        return {64{b}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!mem_resp_i_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, mem_resp_i_valid, 1'b1);
    endtask

    initial begin
        int got;
        bit accepted;
        logic [511:0] exp5 [5];

        tick();
        tick();
        check("rst_valid", mem_resp_i_valid, 1'b0);
        check("rst_count", count_o, 3'd0);
        check("rst_ready", mem_req_o_ready, 1'b1);
        check("rst_data", mem_resp_i_bits_data, '0);
        reset = 1'b0;
        tick();

        // Preload store
        for (int i = 0; i < 16; i++) begin
            wr_valid_i = 1'b1;
            wr_idx_i   = 8'(i);
            wr_data_i  = (i == 5) ? LINE_A5 : pat(i);
            tick();
        end
        wr_valid_i = 1'b0;

        // Basic latency: mcn 0x105 wraps to idx 5
        mem_req_o_valid    = 1'b1;
        mem_req_o_bits_mcn = 58'h105;
        tick();
        mem_req_o_valid = 1'b0;
        check("lat_count1", count_o, 3'd1);
        check("lat_v0", mem_resp_i_valid, 1'b0);
        tick();
        check("lat_v1", mem_resp_i_valid, 1'b0);
        tick();
        check("lat_v2", mem_resp_i_valid, 1'b0);
        tick();
        check("lat_v3", mem_resp_i_valid, 1'b1);
        check("lat_data", mem_resp_i_bits_data, LINE_A5);
        check("lat_count_hold", count_o, 3'd1);
        mem_resp_i_ready = 1'b1;
        tick();
        mem_resp_i_ready = 1'b0;
        check("lat_pop_valid", mem_resp_i_valid, 1'b0);
        check("lat_pop_count", count_o, 3'd0);

        // Fill FIFO, 5th request back-pressured, ordered drain
        for (int k = 1; k <= 4; k++) begin
            mem_req_o_valid    = 1'b1;
            mem_req_o_bits_mcn = 58'(k);
            check("fill_ready", mem_req_o_ready, 1'b1);
            tick();
        end
        mem_req_o_bits_mcn = 58'd5;
        check("full_count", count_o, 3'd4);
        check("full_ready", mem_req_o_ready, 1'b0);
        tick();
        tick();
        check("full_ready_hold", mem_req_o_ready, 1'b0);
        check("full_count_hold", count_o, 3'd4);
        check("full_head_valid", mem_resp_i_valid, 1'b1);
        for (int k = 0; k < 4; k++) exp5[k] = pat(k + 1);
        exp5[4] = LINE_A5;
        mem_resp_i_ready = 1'b1;
        got = 0;
        accepted = 1'b0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (mem_resp_i_valid) begin
                check($sformatf("order_%0d", got), mem_resp_i_bits_data, exp5[got]);
                got++;
            end
            if (mem_req_o_valid && mem_req_o_ready) accepted = 1'b1;
            tick();
            if (accepted) mem_req_o_valid = 1'b0;
        end
        mem_resp_i_ready = 1'b0;
        mem_req_o_valid  = 1'b0;
        check("order_total", got, 5);
        check("order_empty", count_o, 3'd0);

        // Held response is immune to writes and back-pressure
        mem_req_o_valid    = 1'b1;
        mem_req_o_bits_mcn = 58'd6;
        tick();
        mem_req_o_valid = 1'b0;
        wait_valid("hold_wait");
        check("hold_data0", mem_resp_i_bits_data, pat(6));
        for (int c = 0; c < 10; c++) begin
            wr_valid_i = 1'b1;
            wr_idx_i   = 8'd6;
            wr_data_i  = LINE_DEAD;
            tick();
            check($sformatf("hold_v%0d", c), mem_resp_i_valid, 1'b1);
            check($sformatf("hold_d%0d", c), mem_resp_i_bits_data, pat(6));
        end
        wr_valid_i = 1'b0;
        mem_resp_i_ready = 1'b1;
        tick();
        mem_resp_i_ready = 1'b0;
        check("hold_done", mem_resp_i_valid, 1'b0);

        // Stall holds off a due response; cannot retract an asserted one
        stall_i            = 1'b1;
        mem_req_o_valid    = 1'b1;
        mem_req_o_bits_mcn = 58'd5;
        tick();
        mem_req_o_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("stall_v%0d", c), mem_resp_i_valid, 1'b0);
        end
        stall_i = 1'b0;
        tick();
        check("unstall_valid", mem_resp_i_valid, 1'b1);
        check("unstall_data", mem_resp_i_bits_data, LINE_A5);
        stall_i = 1'b1;
        tick();
        check("stall_in_resp", mem_resp_i_valid, 1'b1);
        stall_i = 1'b0;
        mem_resp_i_ready = 1'b1;
        tick();
        mem_resp_i_ready = 1'b0;
        check("stall_pop", mem_resp_i_valid, 1'b0);

        // Write-first: write idx 7 on the edge that registers idx 7
        mem_req_o_valid    = 1'b1;
        mem_req_o_bits_mcn = 58'd7;
        tick();
        mem_req_o_valid = 1'b0;
        tick();
        tick();
        check("wf_pre", mem_resp_i_valid, 1'b0);
        wr_valid_i = 1'b1;
        wr_idx_i   = 8'd7;
        wr_data_i  = LINE_NEW;
        tick();
        wr_valid_i = 1'b0;
        check("wf_valid", mem_resp_i_valid, 1'b1);
        check("wf_data", mem_resp_i_bits_data, LINE_NEW);
        mem_resp_i_ready = 1'b1;
        tick();
        mem_resp_i_ready = 1'b0;

        // Asynchronous reset with outstanding requests
        for (int k = 0; k < 3; k++) begin
            mem_req_o_valid    = 1'b1;
            mem_req_o_bits_mcn = 58'(k + 1);
            tick();
        end
        mem_req_o_valid = 1'b0;
        check("prerst_count", count_o, 3'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", mem_resp_i_valid, 1'b0);
        check("arst_count", count_o, 3'd0);
        check("arst_ready", mem_req_o_ready, 1'b1);
        tick();
        reset = 1'b0;
        mem_resp_i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("post_rst_v%0d", c), mem_resp_i_valid, 1'b0);
        end
        check("post_rst_count", count_o, 3'd0);
        check("post_rst_data", mem_resp_i_bits_data, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
